inst_pf_sched: RTL and testbench

- Sits between the instruction prefetch predictor and the L2 cache request port.
- Buffers predicted next-line addresses in a small FIFO and drops duplicates at cache-line granularity.
- Arbitrates between icache demand misses and buffered prefetches onto a single L2 request channel; demand has priority, with anti-starvation for prefetches.
- Holds each issued request stable until L2 accepts it.

---
 rtl/inst_pf_sched.sv | 186 ++++++++++++++++++
 tb/tb_inst_pf_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_pf_sched.sv
// Instruction prefetch scheduler: dedups predicted next-line prefetches in a small FIFO
// and arbitrates them against icache demand misses onto one L2 request channel.
module inst_pf_sched #(
    parameter int addr_width = 32,
    parameter int LINE_OFF   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_STARVE = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pf_req,
    input  logic [addr_width-1:0] pf_addr,
    input  logic                  dm_valid,
    input  logic [addr_width-1:0] dm_addr,
    output logic                  dm_ready,
    input  logic                  flush,
    output logic                  l2_valid,
    output logic [addr_width-1:0] l2_addr,
    output logic                  l2_is_pf,
    input  logic                  l2_ready,
    output logic [15:0]           pf_drop_cnt
);
    localparam int LW = addr_width - LINE_OFF;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(MAX_STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);
    localparam logic [PW:0]   DEPTH_V    = (PW+1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, HOLD} state_t;
    state_t state, state_n;

    logic [LW-1:0]         fifo_line [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_vld, fifo_vld_n;
    logic [PW-1:0]         head, head_n, tail, tail_n, pop_off, pop_idx;
    logic [PW:0]           occ, occ_n, occ_pop;
    logic [SW-1:0]         starve, starve_n;
    logic [LW-1:0]         last_line, last_line_n;
    logic                  last_vld, last_vld_n;
    logic [15:0]           drop_n;
    logic                  l2_valid_n, l2_is_pf_n;
    logic [addr_width-1:0] l2_addr_n;
    logic                  pop_found, pf_dup, has_pf, demand_win, pf_win, full, wr_en;
    logic [LW-1:0]         pf_line, dm_line, l2_line;
    logic                  unused_low;

    assign pf_line    = pf_addr[addr_width-1:LINE_OFF];
    assign dm_line    = dm_addr[addr_width-1:LINE_OFF];
    assign l2_line    = l2_addr[addr_width-1:LINE_OFF];
    assign unused_low = ^{pf_addr[LINE_OFF-1:0], dm_addr[LINE_OFF-1:0]};

    assign full       = (occ == DEPTH_V);
    assign has_pf     = (|fifo_vld) && !flush;
    assign demand_win = dm_valid && (!has_pf || (starve < STARVE_MAX));
    assign pf_win     = has_pf && (!dm_valid || (starve == STARVE_MAX));
    assign pop_idx    = head + pop_off;

    // Oldest valid entry from head; entries invalidated by a demand are skipped.
    always_comb begin
        pop_off   = '0;
        pop_found = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (!pop_found && fifo_vld[head + PW'(i)]) begin
                pop_off   = PW'(i);
                pop_found = 1'b1;
            end
        end
    end

    always_comb begin
        pf_dup = (l2_valid && (l2_line == pf_line)) || (last_vld && (last_line == pf_line));
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_vld[i] && (fifo_line[i] == pf_line)) pf_dup = 1'b1;
        end
    end

    always_comb begin
        state_n     = state;
        fifo_vld_n  = fifo_vld;
        head_n      = head;
        tail_n      = tail;
        occ_pop     = '0;
        starve_n    = starve;
        last_line_n = last_line;
        last_vld_n  = last_vld;
        drop_n      = pf_drop_cnt;
        l2_valid_n  = l2_valid;
        l2_addr_n   = l2_addr;
        l2_is_pf_n  = l2_is_pf;
        dm_ready    = 1'b0;
        wr_en       = 1'b0;

        case (state)
            IDLE: begin
                if (demand_win) begin
                    dm_ready   = 1'b1;
                    state_n    = HOLD;
                    l2_valid_n = 1'b1;
                    l2_addr_n  = {dm_line, {LINE_OFF{1'b0}}};
                    l2_is_pf_n = 1'b0;
                    if (has_pf) starve_n = starve + 1'b1;
                    for (int i = 0; i < FIFO_DEPTH; i++) begin
                        if (fifo_vld[i] && (fifo_line[i] == dm_line)) fifo_vld_n[i] = 1'b0;
                    end
                end else if (pf_win) begin
                    state_n             = HOLD;
                    l2_valid_n          = 1'b1;
                    l2_addr_n           = {fifo_line[pop_idx], {LINE_OFF{1'b0}}};
                    l2_is_pf_n          = 1'b1;
                    starve_n            = '0;
                    fifo_vld_n[pop_idx] = 1'b0;
                    head_n              = pop_idx + 1'b1;
                    occ_pop             = (PW+1)'(pop_off) + 1'b1;
                end
            end
            HOLD: begin
                if (l2_ready) begin
                    state_n     = IDLE;
                    l2_valid_n  = 1'b0;
                    last_line_n = l2_line;
                    last_vld_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Fullness is judged before any same-cycle pop.
        if (pf_req && !flush && !pf_dup) begin
            if (!full) begin
                wr_en            = 1'b1;
                fifo_vld_n[tail] = 1'b1;
                tail_n           = tail + 1'b1;
            end else if (pf_drop_cnt != 16'hFFFF) begin
                drop_n = pf_drop_cnt + 16'd1;
            end
        end

        occ_n = occ - occ_pop + (PW+1)'(wr_en);

        if (flush) begin
            fifo_vld_n = '0;
            last_vld_n = 1'b0;
            starve_n   = '0;
        end

        // Once nothing valid remains, reclaim any slots held by invalidated entries.
        if (fifo_vld_n == '0) begin
            head_n   = tail_n;
            occ_n    = '0;
            starve_n = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            fifo_vld    <= '0;
            head        <= '0;
            tail        <= '0;
            occ         <= '0;
            starve      <= '0;
            last_line   <= '0;
            last_vld    <= 1'b0;
            pf_drop_cnt <= '0;
            l2_valid    <= 1'b0;
            l2_addr     <= '0;
            l2_is_pf    <= 1'b0;
        end else begin
            state       <= state_n;
            fifo_vld    <= fifo_vld_n;
            head        <= head_n;
            tail        <= tail_n;
            occ         <= occ_n;
            starve      <= starve_n;
            last_line   <= last_line_n;
            last_vld    <= last_vld_n;
            pf_drop_cnt <= drop_n;
            l2_valid    <= l2_valid_n;
            l2_addr     <= l2_addr_n;
            l2_is_pf    <= l2_is_pf_n;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) fifo_line[tail] <= pf_line;
    end
endmodule

// File: tb/tb_inst_pf_sched.sv
// Directed self-checking bench for inst_pf_sched: dedup, FIFO overflow, starvation,
// flush, demand invalidation and reset behaviour.
module tb_inst_pf_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        pf_req;
    logic [31:0] pf_addr;
    logic        dm_valid;
    logic [31:0] dm_addr;
    logic        dm_ready;
    logic        flush;
    logic        l2_valid;
    logic [31:0] l2_addr;
    logic        l2_is_pf;
    logic        l2_ready;
    logic [15:0] pf_drop_cnt;

    int checks = 0;
    int errors = 0;

    inst_pf_sched #(.addr_width(32), .LINE_OFF(4), .FIFO_DEPTH(4), .MAX_STARVE(8)) dut (
        .clk(clk), .rst(rst), .pf_req(pf_req), .pf_addr(pf_addr),
        .dm_valid(dm_valid), .dm_addr(dm_addr), .dm_ready(dm_ready), .flush(flush),
        .l2_valid(l2_valid), .l2_addr(l2_addr), .l2_is_pf(l2_is_pf),
        .l2_ready(l2_ready), .pf_drop_cnt(pf_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; pf_req = 1'b0; pf_addr = '0; dm_valid = 1'b0; dm_addr = '0;
        flush = 1'b0; l2_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (l2_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_l2_valid got %0b exp 0", l2_valid); end
        checks++; if (l2_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_l2_addr got %h exp 0", l2_addr); end
        checks++; if (l2_is_pf !== 1'b0) begin errors++; $display("[TB] FAIL rst_l2_is_pf got %0b exp 0", l2_is_pf); end
        checks++; if (dm_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_dm_ready got %0b exp 0", dm_ready); end
        checks++; if (pf_drop_cnt !== 16'h0) begin errors++; $display("[TB] FAIL rst_drop got %0d exp 0", pf_drop_cnt); end
    endtask

    task automatic test_single_prefetch();
        do_reset();
        l2_ready = 1'b1; pf_req = 1'b1; pf_addr = 32'h1000;
        tick(); pf_req = 1'b0;
        checks++; if (l2_valid !== 1'b0) begin errors++; $display("[TB] FAIL pf1_early got %0b exp 0", l2_valid); end
        tick();
        checks++; if (l2_valid !== 1'b1) begin errors++; $display("[TB] FAIL pf1_valid got %0b exp 1", l2_valid); end
        checks++; if (l2_addr !== 32'h1000) begin errors++; $display("[TB] FAIL pf1_addr got %h exp 1000", l2_addr); end
        checks++; if (l2_is_pf !== 1'b1) begin errors++; $display("[TB] FAIL pf1_is_pf got %0b exp 1", l2_is_pf); end
        tick();
        checks++; if (l2_valid !== 1'b0) begin errors++; $display("[TB] FAIL pf1_release got %0b exp 0", l2_valid); end
    endtask

    task automatic test_dedup();
        int grants = 0;
        logic [31:0] first_addr = '0;
        logic [31:0] addrs [3];
        addrs[0] = 32'h1000; addrs[1] = 32'h1004; addrs[2] = 32'h1008;
        do_reset();
        l2_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pf_req = 1'b1; pf_addr = addrs[i];
            tick();
            if (l2_valid) begin if (grants == 0) first_addr = l2_addr; grants++; end
        end
        pf_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (l2_valid) begin if (grants == 0) first_addr = l2_addr; grants++; end
        end
        checks++; if (grants !== 1) begin errors++; $display("[TB] FAIL dedup_grants got %0d exp 1", grants); end
        checks++; if (first_addr !== 32'h1000) begin errors++; $display("[TB] FAIL dedup_addr got %h exp 1000", first_addr); end
        checks++; if (pf_drop_cnt !== 16'h0) begin errors++; $display("[TB] FAIL dedup_drop got %0d exp 0", pf_drop_cnt); end
    endtask

    task automatic test_fifo_full();
        do_reset();
        l2_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            pf_req = 1'b1; pf_addr = 32'(i) * 32'h10;
            tick();
        end
        pf_req = 1'b0;
        checks++; if (pf_drop_cnt !== 16'd1) begin errors++; $display("[TB] FAIL full_drop got %0d exp 1", pf_drop_cnt); end
        checks++; if (l2_valid !== 1'b1) begin errors++; $display("[TB] FAIL full_hold_valid got %0b exp 1", l2_valid); end
        checks++; if (l2_addr !== 32'h10) begin errors++; $display("[TB] FAIL full_hold_addr got %h exp 10", l2_addr); end
        l2_ready = 1'b1;
        tick();
        l2_ready = 1'b0;
        checks++; if (l2_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_release got %0b exp 0", l2_valid); end
        pf_req = 1'b1; pf_addr = 32'h70;
        tick(); pf_req = 1'b0;
        checks++; if (pf_drop_cnt !== 16'd2) begin errors++; $display("[TB] FAIL full_popdrop got %0d exp 2", pf_drop_cnt); end
        checks++; if (l2_addr !== 32'h20) begin errors++; $display("[TB] FAIL full_next_addr got %h exp 20", l2_addr); end
        checks++; if (l2_is_pf !== 1'b1) begin errors++; $display("[TB] FAIL full_next_is_pf got %0b exp 1", l2_is_pf); end
    endtask

    task automatic test_starvation();
        int k = 0;
        int n = 0;
        logic accepted;
        logic [31:0] got_addr [10];
        logic        got_pf   [10];
        logic [31:0] exp_addr;
        do_reset();
        l2_ready = 1'b1;
        pf_req = 1'b1; pf_addr = 32'h200;
        tick();
        pf_req = 1'b0; dm_valid = 1'b1; dm_addr = 32'h1004;
        for (int c = 0; c < 60 && n < 10; c++) begin
            #1 accepted = dm_ready;
            tick();
            if (accepted) begin
                k++;
                if (k == 9) dm_valid = 1'b0;
                else dm_addr = 32'h1004 + 32'(k) * 32'h10;
            end
            if (l2_valid) begin got_addr[n] = l2_addr; got_pf[n] = l2_is_pf; n++; end
        end
        dm_valid = 1'b0;
        checks++; if (n !== 10) begin errors++; $display("[TB] FAIL starve_count got %0d exp 10", n); end
        for (int i = 0; i < n; i++) begin
            exp_addr = (i < 8) ? 32'h1000 + 32'(i) * 32'h10 : ((i == 8) ? 32'h200 : 32'h1080);
            checks++; if (got_pf[i] !== (i == 8)) begin errors++; $display("[TB] FAIL starve_is_pf[%0d] got %0b exp %0b", i, got_pf[i], (i == 8)); end
            checks++; if (got_addr[i] !== exp_addr) begin errors++; $display("[TB] FAIL starve_addr[%0d] got %h exp %h", i, got_addr[i], exp_addr); end
        end
    endtask

    task automatic test_flush();
        int pfc = 0;
        int dmc = 0;
        logic accepted;
        do_reset();
        l2_ready = 1'b0;
        pf_req = 1'b1; pf_addr = 32'h2f0; tick();
        pf_addr = 32'h300; tick();
        pf_addr = 32'h310; tick();
        flush = 1'b1; pf_addr = 32'h320; tick();
        flush = 1'b0; pf_req = 1'b0;
        checks++; if (l2_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_hold_valid got %0b exp 1", l2_valid); end
        checks++; if (l2_addr !== 32'h2f0) begin errors++; $display("[TB] FAIL flush_hold_addr got %h exp 2f0", l2_addr); end
        checks++; if (pf_drop_cnt !== 16'h0) begin errors++; $display("[TB] FAIL flush_drop got %0d exp 0", pf_drop_cnt); end
        dm_valid = 1'b1; dm_addr = 32'h600;
        #1;
        checks++; if (dm_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_dm_ready got %0b exp 0", dm_ready); end
        l2_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            accepted = dm_ready;
            tick();
            if (accepted) dm_valid = 1'b0;
            if (l2_valid && l2_is_pf) pfc++;
            if (l2_valid && !l2_is_pf) dmc++;
            #1;
        end
        checks++; if (pfc !== 0) begin errors++; $display("[TB] FAIL flush_pf_grants got %0d exp 0", pfc); end
        checks++; if (dmc !== 1) begin errors++; $display("[TB] FAIL flush_dm_grants got %0d exp 1", dmc); end
    endtask

    task automatic test_demand_invalidate();
        int grants = 0;
        do_reset();
        l2_ready = 1'b0;
        pf_req = 1'b1; pf_addr = 32'h3f0; tick();
        pf_addr = 32'h400; tick();
        pf_req = 1'b0; l2_ready = 1'b1;
        tick();
        dm_valid = 1'b1; dm_addr = 32'h408;
        #1;
        checks++; if (dm_ready !== 1'b1) begin errors++; $display("[TB] FAIL inval_dm_ready got %0b exp 1", dm_ready); end
        tick();
        dm_valid = 1'b0;
        checks++; if (l2_addr !== 32'h400) begin errors++; $display("[TB] FAIL inval_addr got %h exp 400", l2_addr); end
        checks++; if (l2_is_pf !== 1'b0) begin errors++; $display("[TB] FAIL inval_is_pf got %0b exp 0", l2_is_pf); end
        for (int c = 0; c < 6; c++) begin
            tick();
            if (l2_valid) grants++;
        end
        checks++; if (grants !== 0) begin errors++; $display("[TB] FAIL inval_later_grants got %0d exp 0", grants); end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        l2_ready = 1'b0;
        pf_req = 1'b1; pf_addr = 32'h500; tick();
        pf_req = 1'b0; tick();
        checks++; if (l2_valid !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre got %0b exp 1", l2_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (l2_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_async got %0b exp 0", l2_valid); end
        rst = 1'b0;
        tick(); tick();
        checks++; if (l2_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_after got %0b exp 0", l2_valid); end
    endtask

    initial begin
        $display("[TB] starting inst_pf_sched bench");
        test_reset();
        test_single_prefetch();
        test_dedup();
        test_fifo_full();
        test_starvation();
        test_flush();
        test_demand_invalidate();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
